// File: rtl/gcd_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_request_arbiter
//  Purpose  : Round-robin sharing of one subtractive GCD engine between
//             NUM_REQ requesters, with zero-operand bypass and watchdog abort.
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_a,
    output logic [DATA_W-1:0]         eng_b,
    output logic                      eng_rst,
    input  logic                      eng_done,
    input  logic [DATA_W-1:0]         eng_result,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    localparam int c_TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_rr;
    logic [IDX_W-1:0]     r_grant;
    logic [DATA_W-1:0]    r_eng_a;
    logic [DATA_W-1:0]    r_eng_b;
    logic [DATA_W-1:0]    r_rsp_data;
    logic                 r_rsp_err;
    logic                 r_abort;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 w_found;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_zero_op;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   w_grant_1h;

    // (base + off) mod NUM_REQ, with off < NUM_REQ
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ)
            sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[f_wrap(r_rr, i)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap(r_rr, i);
            end
        end
    end

    assign w_zero_op = (r_eng_a == '0) || (r_eng_b == '0);
    assign w_timeout = (r_timer == c_TMR_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = w_zero_op ? S_RESP : S_WAIT;
            S_WAIT:  if (eng_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_grant    <= '0;
            r_eng_a    <= '0;
            r_eng_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_abort    <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_eng_a <= req_a[w_sel*DATA_W +: DATA_W];
                        r_eng_b <= req_b[w_sel*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    // gcd(x,0) = x and gcd(0,0) = 0, so the OR is the answer
                    if (w_zero_op) begin
                        r_rsp_data <= r_eng_a | r_eng_b;
                        r_rsp_err  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                    if (eng_done) begin
                        r_rsp_data <= eng_result;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_abort    <= 1'b1;
                    end
                end
                S_RESP: r_rr <= f_wrap(r_grant, 1);
                default: ;
            endcase
        end
    end

    assign w_grant_1h = NUM_REQ'(1) << r_grant;
    assign req_ready  = (r_state == S_ISSUE) ? w_grant_1h : '0;
    assign rsp_valid  = (r_state == S_RESP) ? w_grant_1h : '0;
    assign eng_start  = (r_state == S_ISSUE) && !w_zero_op;
    assign eng_rst    = rst | r_abort;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;
    assign eng_a      = r_eng_a;
    assign eng_b      = r_eng_b;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_request_arbiter
//  Purpose  : Directed bench for gcd_request_arbiter with a transaction model
//             and a behavioural GCD engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_request_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            eng_start;
    logic [DW-1:0]   eng_a;
    logic [DW-1:0]   eng_b;
    logic            eng_rst;
    logic            eng_done = 1'b0;
    logic [DW-1:0]   eng_result = '0;
    logic            busy;
    logic [IW-1:0]   grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eng_delay = 1;
    int eng_cnt = -1;
    int rsp_seen = 0;
    logic [N-1:0] hold = '0;

    gcd_request_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_rst(eng_rst),
        .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int gcd(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural engine: eng_done pulses eng_delay cycles after eng_start
    always @(posedge clk) begin
        #1;
        eng_done = 1'b0;
        if (eng_rst) begin
            eng_cnt = -1;
        end else if (eng_start) begin
            eng_cnt    = (eng_delay >= 1) ? eng_delay : -1;
            eng_result = DW'(gcd(int'(eng_a), int'(eng_b)));
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                eng_cnt  = -1;
            end
        end
    end

    // Transaction-level model of the arbiter
    int m_rr = 0, m_gid = 0, m_a = 0, m_b = 0;
    int exp_start = -1, exp_rsp = -1, exp_abort = -1, exp_data = 0, exp_err = 0;
    int m_eng_a = 0, m_eng_b = 0, m_last_data = 0, m_last_err = 0;
    int n_start = 0, n_abort = 0;
    bit inflight = 0, m_busy_prev = 0, rst_prev = 0;
    logic [N-1:0]    exp_ready, exp_rv;
    logic [N-1:0]    prev_valid = '0;
    logic [N*DW-1:0] prev_a = '0, prev_b = '0;
    int log_id[$], log_data[$], log_err[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("eng_rst_in_reset", 32'(eng_rst), 1);
            if (rst_prev) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                chk("rst_rsp_err", 32'(rsp_err), 0);
                chk("rst_eng_start", 32'(eng_start), 0);
                chk("rst_eng_a", 32'(eng_a), 0);
                chk("rst_eng_b", 32'(eng_b), 0);
                chk("rst_grant_id", 32'(grant_id), 0);
            end
            m_rr = 0; m_gid = 0; inflight = 0; m_busy_prev = 0;
            exp_start = -1; exp_rsp = -1; exp_abort = -1;
            m_eng_a = 0; m_eng_b = 0; m_last_data = 0; m_last_err = 0;
            prev_valid = '0;
        end else begin
            exp_ready = '0;
            if (!m_busy_prev && prev_valid != '0) begin
                m_gid     = pick(prev_valid, m_rr);
                m_a       = int'(prev_a[m_gid*DW +: DW]);
                m_b       = int'(prev_b[m_gid*DW +: DW]);
                m_eng_a   = m_a;
                m_eng_b   = m_b;
                inflight  = 1;
                exp_ready = N'(1) << m_gid;
                exp_abort = -1;
                if (m_a == 0 || m_b == 0) begin
                    exp_start = -1;
                    exp_rsp   = cyc + 1;
                    exp_data  = m_a | m_b;
                    exp_err   = 0;
                end else begin
                    exp_start = cyc;
                    if (eng_delay >= 1 && eng_delay <= TO) begin
                        exp_rsp  = cyc + eng_delay + 1;
                        exp_data = gcd(m_a, m_b);
                        exp_err  = 0;
                    end else begin
                        exp_rsp   = cyc + TO + 1;
                        exp_abort = cyc + TO + 1;
                        exp_data  = 0;
                        exp_err   = 1;
                    end
                end
            end
            chk("busy", 32'(busy), 32'(inflight));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("grant_id", 32'(grant_id), m_gid);
            chk("eng_start", 32'(eng_start), 32'(cyc == exp_start));
            chk("eng_rst", 32'(eng_rst), 32'(cyc == exp_abort));
            exp_rv = (cyc == exp_rsp) ? (N'(1) << m_gid) : '0;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (cyc == exp_rsp) begin
                m_last_data = exp_data;
                m_last_err  = exp_err;
                m_rr        = (m_gid + 1) % N;
                log_id.push_back(m_gid);
                log_data.push_back(exp_data);
                log_err.push_back(exp_err);
            end
            chk("rsp_data", 32'(rsp_data), m_last_data);
            chk("rsp_err", 32'(rsp_err), m_last_err);
            chk("eng_a", 32'(eng_a), m_eng_a);
            chk("eng_b", 32'(eng_b), m_eng_b);
            m_busy_prev = inflight;
            if (cyc == exp_rsp) inflight = 0;
            if (eng_start) n_start++;
            if (eng_rst) n_abort++;
            prev_valid = req_valid;
            prev_a     = req_a;
            prev_b     = req_b;
        end
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (req_ready[i] && !hold[i]) req_valid[i] = 1'b0;
        if (rsp_valid != '0) rsp_seen++;
    endtask

    task automatic req(input int p, input int a, input int b);
        req_a[p*DW +: DW] = DW'(a);
        req_b[p*DW +: DW] = DW'(b);
        req_valid[p]      = 1'b1;
    endtask

    task automatic run_quiet(input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((req_valid != '0 || busy) && n < maxc);
        if (req_valid != '0 || busy) begin
            checks++;
            errors++;
            $display("FAIL quiet_timeout: busy=%0b req_valid=%0h, expected idle within %0d cycles", busy, req_valid, maxc);
            req_valid = '0;
            hold      = '0;
        end
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int exp_ids[14]  = '{0, 0, 1, 2, 3, 0, 2, 3, 1, 2, 0, 2, 1, 3};
    int exp_dat[14]  = '{6, 4, 7, 27, 1, 4, 35, 0, 0, 3, 25, 7, 2, 5};
    int exp_errs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single requester through the engine
        eng_delay = 4;
        req(0, 48, 18);
        run_quiet(50);

        // all four held: full round-robin then back to 0
        pulse_reset();
        eng_delay = 3;
        hold      = '1;
        rsp_seen  = 0;
        req(0, 12, 8); req(1, 35, 21); req(2, 81, 27); req(3, 17, 5);
        n = 0;
        while (rsp_seen < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("rr_rsp_count", rsp_seen, 5);
        req_valid = '0;
        hold      = '0;
        run_quiet(50);

        // zero-operand bypass
        req(2, 0, 35);
        run_quiet(20);
        req(3, 0, 0);
        run_quiet(20);

        // watchdog abort, then a normal transaction
        eng_delay = -1;
        req(1, 9, 6);
        run_quiet(100);
        eng_delay = 3;
        req(2, 9, 6);
        run_quiet(50);

        // done on the last permitted WAIT cycle
        eng_delay = TO;
        req(0, 100, 75);
        run_quiet(100);

        // reset mid-WAIT drops the transaction and restarts round-robin at 0
        eng_delay = 2;
        req(2, 14, 21);
        run_quiet(50);
        eng_delay = -1;
        req(3, 5, 10);
        repeat (6) tick();
        rst = 1'b1;
        req(1, 6, 4);
        req(3, 5, 10);
        eng_delay = 2;
        tick();
        tick();
        rst = 1'b0;
        run_quiet(100);

        chk("rsp_log_len", log_id.size(), 14);
        for (int i = 0; i < 14; i++) begin
            if (i < log_id.size()) begin
                chk($sformatf("log_id[%0d]", i), log_id[i], exp_ids[i]);
                chk($sformatf("log_data[%0d]", i), log_data[i], exp_dat[i]);
                chk($sformatf("log_err[%0d]", i), log_err[i], exp_errs[i]);
            end
        end
        chk("eng_start_total", n_start, 13);
        chk("abort_pulse_total", n_abort, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
